instr_fetch32: RTL and testbench

//  Instruction-fetch stage of the single-cycle MIPS CPU. Owns the PC register, drives a

---
 rtl/instr_fetch32.sv | 108 ++++++++++
 tb/tb_instr_fetch32.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch32.sv
// Fetch stage: owns PC, drives the synchronous instruction ROM,
// resolves next PC from branch/jump controls and halts on bad targets.
module instr_fetch32 #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          IMEM_AW  = 14
) (
   input  logic               clock,
   input  logic               reset_n,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [31:0]        imem_rdata,
   input  logic               stall,
   input  logic [31:0]        Addr_result,
   input  logic [31:0]        Read_data_1,
   input  logic               Branch,
   input  logic               nBranch,
   input  logic               Jmp,
   input  logic               Jal,
   input  logic               Jr,
   input  logic               Zero,
   output logic [31:0]        Instruction,
   output logic [5:0]         Opcode,
   output logic [5:0]         Function_opcode,
   output logic               inst_valid,
   output logic [31:0]        pc,
   output logic [31:0]        branch_base_addr,
   output logic [31:0]        link_addr,
   output logic               fetch_fault
);

   localparam int SH = IMEM_AW + 2;

   typedef enum logic [1:0] {
      BOOT,
      RUN,
      HALT
   } state_t;

   state_t      state;
   logic [31:0] pc_plus4;
   logic [31:0] next_pc;
   logic [31:0] hi_bits;
   logic        taken;
   logic        sel_br;
   logic        bad_align;
   logic        bad_range;
   logic        fault;

   assign pc_plus4         = pc + 32'd4;
   assign branch_base_addr = pc_plus4;
   assign link_addr        = pc_plus4;

   assign inst_valid  = (state == RUN) & ~stall;
   assign Instruction = inst_valid ? imem_rdata : 32'h0;
   assign Opcode          = Instruction[31:26];
   assign Function_opcode = Instruction[5:0];

   assign taken = (Branch & Zero) | (nBranch & ~Zero);

   always_comb begin
      next_pc = pc_plus4;
      sel_br  = 1'b0;
      if (Jr) begin
         next_pc = {Read_data_1[31:2], 2'b00};
      end else if (Jmp | Jal) begin
         next_pc = {pc_plus4[31:28], Instruction[25:0], 2'b00};
      end else if (taken) begin
         next_pc = Addr_result;
         sel_br  = 1'b1;
      end
   end

   // Anything above the ROM window is illegal, including pc+4 wrap.
   assign hi_bits   = next_pc >> SH;
   assign bad_range = |hi_bits;
   assign bad_align = (Jr & (|Read_data_1[1:0]))
                    | (sel_br & (|Addr_result[1:0]));
   assign fault     = inst_valid & (bad_align | bad_range);

   // Stall/HALT re-read the current word so imem_rdata stays aligned with pc.
   always_comb begin
      imem_addr = pc[IMEM_AW+1:2];
      if (inst_valid)
         imem_addr = next_pc[IMEM_AW+1:2];
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= BOOT;
         pc          <= RESET_PC;
         fetch_fault <= 1'b0;
      end else begin
         unique case (state)
            BOOT: state <= RUN;
            RUN: begin
               if (fault) begin
                  fetch_fault <= 1'b1;
                  state       <= HALT;
               end else if (!stall) begin
                  pc <= next_pc;
               end
            end
            HALT: state <= HALT;
            default: state <= BOOT;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch32.sv
// Bench for instr_fetch32: ROM model, scoreboard of expected pc/instruction,
// scenarios for sequencing, branches, jumps, faults, stall and reset.
module tb_instr_fetch32;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        stall, Branch, nBranch, Jmp, Jal, Jr, Zero;
   logic [31:0] Addr_result, Read_data_1;

   logic [13:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] Instruction, pc, branch_base_addr, link_addr;
   logic [5:0]  Opcode, Function_opcode;
   logic        inst_valid, fetch_fault;

   logic [3:0]  imem_addr4;
   logic [31:0] imem_rdata4;
   logic [31:0] Instruction4, pc4, bba4, link4;
   logic [5:0]  Opcode4, Function_opcode4;
   logic        inst_valid4, fetch_fault4;

   logic [31:0] rom [256];

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_run = 0;
   int   n_fail = 0;

   always #5 clock = ~clock;

   always @(posedge clock) begin
      imem_rdata  <= rom[imem_addr[7:0]];
      imem_rdata4 <= rom[{4'd0, imem_addr4}];
   end

   instr_fetch32 dut (
      .clock(clock), .reset_n(reset_n),
      .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .stall(stall), .Addr_result(Addr_result),
      .Read_data_1(Read_data_1), .Branch(Branch),
      .nBranch(nBranch), .Jmp(Jmp), .Jal(Jal), .Jr(Jr),
      .Zero(Zero), .Instruction(Instruction),
      .Opcode(Opcode), .Function_opcode(Function_opcode),
      .inst_valid(inst_valid), .pc(pc),
      .branch_base_addr(branch_base_addr),
      .link_addr(link_addr), .fetch_fault(fetch_fault)
   );

   instr_fetch32 #(.RESET_PC(32'h0), .IMEM_AW(4)) dut4 (
      .clock(clock), .reset_n(reset_n),
      .imem_addr(imem_addr4), .imem_rdata(imem_rdata4),
      .stall(stall), .Addr_result(Addr_result),
      .Read_data_1(Read_data_1), .Branch(Branch),
      .nBranch(nBranch), .Jmp(Jmp), .Jal(Jal), .Jr(Jr),
      .Zero(Zero), .Instruction(Instruction4),
      .Opcode(Opcode4), .Function_opcode(Function_opcode4),
      .inst_valid(inst_valid4), .pc(pc4),
      .branch_base_addr(bba4),
      .link_addr(link4), .fetch_fault(fetch_fault4)
   );

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic clr();
      stall = 0; Branch = 0; nBranch = 0; Jmp = 0;
      Jal = 0; Jr = 0; Zero = 0;
      Addr_result = 0; Read_data_1 = 0;
   endtask

   task automatic boot();
      clr();
      reset_n = 0;
      repeat (2) step();
      reset_n = 1;
      step();
   endtask

   task automatic goto_pc(input logic [31:0] a);
      Jr = 1;
      Read_data_1 = a;
      step();
      Jr = 0;
      Read_data_1 = 0;
   endtask

   task automatic test_reset();
      clr();
      reset_n = 0;
      repeat (2) step();
      n_run++;
      if (pc !== 32'h0 || fetch_fault !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_regs got=%h/%b exp=0/0", pc, fetch_fault);
      end
      reset_n = 1;
      #1;
      n_run++;
      if (inst_valid !== 1'b0 || Instruction !== 32'h0) begin
         n_fail++;
         $display("FAIL boot_valid got=%b/%h exp=0/0", inst_valid, Instruction);
      end
      n_run++;
      if (imem_addr !== 14'd0) begin
         n_fail++;
         $display("FAIL boot_addr got=%h exp=0", imem_addr);
      end
      for (int i = 0; i < 4; i++)
         sb.push_back('{pc: 32'(i * 4), ins: rom[i]});
      for (int i = 0; i < 4; i++) begin
         step();
         e = sb.pop_front();
         n_run++;
         if (pc !== e.pc || inst_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL seq_pc got=%h/%b exp=%h/1", pc, inst_valid, e.pc);
         end
         n_run++;
         if (Instruction !== e.ins) begin
            n_fail++;
            $display("FAIL seq_ins got=%h exp=%h", Instruction, e.ins);
         end
         n_run++;
         if (Opcode !== e.ins[31:26] || Function_opcode !== e.ins[5:0]) begin
            n_fail++;
            $display("FAIL seq_slice got=%h/%h exp=%h/%h",
                     Opcode, Function_opcode, e.ins[31:26], e.ins[5:0]);
         end
      end
   endtask

   task automatic test_branch();
      boot();
      goto_pc(32'h10);
      Branch = 1; Zero = 1; Addr_result = 32'h40;
      #1;
      n_run++;
      if (pc !== 32'h10 || branch_base_addr !== 32'h14) begin
         n_fail++;
         $display("FAIL beq_setup got=%h/%h exp=10/14", pc, branch_base_addr);
      end
      n_run++;
      if (imem_addr !== 14'h10) begin
         n_fail++;
         $display("FAIL beq_iaddr got=%h exp=10", imem_addr);
      end
      sb.push_back('{pc: 32'h40, ins: rom[16]});
      step();
      clr();
      e = sb.pop_front();
      n_run++;
      if (pc !== e.pc || Instruction !== e.ins) begin
         n_fail++;
         $display("FAIL beq_taken got=%h/%h exp=%h/%h", pc, Instruction, e.pc, e.ins);
      end
      goto_pc(32'h10);
      Branch = 1; Zero = 0; Addr_result = 32'h40;
      sb.push_back('{pc: 32'h14, ins: rom[5]});
      step();
      clr();
      e = sb.pop_front();
      n_run++;
      if (pc !== e.pc || Instruction !== e.ins) begin
         n_fail++;
         $display("FAIL beq_not got=%h/%h exp=%h/%h", pc, Instruction, e.pc, e.ins);
      end
      goto_pc(32'h10);
      nBranch = 1; Zero = 0; Addr_result = 32'h40;
      sb.push_back('{pc: 32'h40, ins: rom[16]});
      step();
      clr();
      e = sb.pop_front();
      n_run++;
      if (pc !== e.pc || Instruction !== e.ins) begin
         n_fail++;
         $display("FAIL bne_taken got=%h/%h exp=%h/%h", pc, Instruction, e.pc, e.ins);
      end
   endtask

   task automatic test_jump();
      rom[2] = {6'h03, 26'h000_0020};
      boot();
      step();
      step();
      Jal = 1;
      #1;
      n_run++;
      if (pc !== 32'h8 || link_addr !== 32'hC) begin
         n_fail++;
         $display("FAIL jal_link got=%h/%h exp=8/c", pc, link_addr);
      end
      n_run++;
      if (Opcode !== 6'h03 || imem_addr !== 14'h20) begin
         n_fail++;
         $display("FAIL jal_decode got=%h/%h exp=03/20", Opcode, imem_addr);
      end
      sb.push_back('{pc: 32'h80, ins: rom[32]});
      step();
      clr();
      e = sb.pop_front();
      n_run++;
      if (pc !== e.pc || Instruction !== e.ins) begin
         n_fail++;
         $display("FAIL jal_target got=%h/%h exp=%h/%h", pc, Instruction, e.pc, e.ins);
      end
      goto_pc(32'h8);
      Jmp = 1;
      sb.push_back('{pc: 32'h80, ins: rom[32]});
      step();
      clr();
      e = sb.pop_front();
      n_run++;
      if (pc !== e.pc || Instruction !== e.ins) begin
         n_fail++;
         $display("FAIL j_target got=%h/%h exp=%h/%h", pc, Instruction, e.pc, e.ins);
      end
   endtask

   task automatic test_jr_fault();
      boot();
      goto_pc(32'h20);
      Jr = 1; Read_data_1 = 32'h0000_0102;
      #1;
      n_run++;
      if (inst_valid !== 1'b1 || fetch_fault !== 1'b0) begin
         n_fail++;
         $display("FAIL jr_exec got=%b/%b exp=1/0", inst_valid, fetch_fault);
      end
      step();
      clr();
      n_run++;
      if (fetch_fault !== 1'b1 || pc !== 32'h20) begin
         n_fail++;
         $display("FAIL jr_fault got=%b/%h exp=1/20", fetch_fault, pc);
      end
      repeat (2) step();
      n_run++;
      if (pc !== 32'h20 || inst_valid !== 1'b0 || Instruction !== 32'h0
          || fetch_fault !== 1'b1) begin
         n_fail++;
         $display("FAIL halt_hold got=%h/%b/%h exp=20/0/0", pc, inst_valid, Instruction);
      end
      boot();
      n_run++;
      if (fetch_fault !== 1'b0) begin
         n_fail++;
         $display("FAIL jr_rst got=%b exp=0", fetch_fault);
      end
      Jr = 1; Read_data_1 = 32'h100;
      sb.push_back('{pc: 32'h100, ins: rom[64]});
      step();
      clr();
      e = sb.pop_front();
      n_run++;
      if (pc !== e.pc || Instruction !== e.ins || fetch_fault !== 1'b0) begin
         n_fail++;
         $display("FAIL jr_ok got=%h/%h exp=%h/%h", pc, Instruction, e.pc, e.ins);
      end
   endtask

   task automatic test_stall();
      boot();
      goto_pc(32'h24);
      stall = 1;
      #1;
      n_run++;
      if (inst_valid !== 1'b0 || Instruction !== 32'h0 || imem_addr !== 14'd9) begin
         n_fail++;
         $display("FAIL stall_out got=%b/%h/%h exp=0/0/9", inst_valid, Instruction, imem_addr);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         n_run++;
         if (pc !== 32'h24 || inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_hold got=%h/%b exp=24/0", pc, inst_valid);
         end
      end
      Jmp = 1;
      step();
      n_run++;
      if (pc !== 32'h24) begin
         n_fail++;
         $display("FAIL stall_jmp got=%h exp=24", pc);
      end
      Jmp = 0; Jr = 1; Read_data_1 = 32'h102;
      step();
      n_run++;
      if (fetch_fault !== 1'b0 || pc !== 32'h24) begin
         n_fail++;
         $display("FAIL stall_fault got=%b/%h exp=0/24", fetch_fault, pc);
      end
      clr();
      #1;
      n_run++;
      if (inst_valid !== 1'b1 || Instruction !== rom[9]) begin
         n_fail++;
         $display("FAIL stall_rel got=%b/%h exp=1/%h", inst_valid, Instruction, rom[9]);
      end
      sb.push_back('{pc: 32'h28, ins: rom[10]});
      step();
      e = sb.pop_front();
      n_run++;
      if (pc !== e.pc || Instruction !== e.ins) begin
         n_fail++;
         $display("FAIL stall_next got=%h/%h exp=%h/%h", pc, Instruction, e.pc, e.ins);
      end
   endtask

   task automatic test_reset_pulse();
      boot();
      step();
      step();
      reset_n = 0;
      #1;
      n_run++;
      if (pc !== 32'h0 || inst_valid !== 1'b0 || imem_addr !== 14'd0) begin
         n_fail++;
         $display("FAIL rst_run got=%h/%b/%h exp=0/0/0", pc, inst_valid, imem_addr);
      end
      #1;
      reset_n = 1;
      step();
      n_run++;
      if (pc !== 32'h0 || inst_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_boot got=%h/%b exp=0/1", pc, inst_valid);
      end
      goto_pc(32'h20);
      Jr = 1; Read_data_1 = 32'h103;
      step();
      clr();
      reset_n = 0;
      #1;
      n_run++;
      if (fetch_fault !== 1'b0 || pc !== 32'h0) begin
         n_fail++;
         $display("FAIL rst_halt got=%b/%h exp=0/0", fetch_fault, pc);
      end
      #1;
      reset_n = 1;
      step();
      n_run++;
      if (inst_valid !== 1'b1 || Instruction !== rom[0]) begin
         n_fail++;
         $display("FAIL rst_resume got=%b/%h exp=1/%h", inst_valid, Instruction, rom[0]);
      end
   endtask

   task automatic test_rom_range();
      boot();
      Branch = 1; Zero = 1; Addr_result = 32'h40;
      #1;
      n_run++;
      if (inst_valid4 !== 1'b1 || fetch_fault4 !== 1'b0) begin
         n_fail++;
         $display("FAIL rng_pre got=%b/%b exp=1/0", inst_valid4, fetch_fault4);
      end
      step();
      clr();
      n_run++;
      if (fetch_fault4 !== 1'b1 || pc4 !== 32'h0 || inst_valid4 !== 1'b0) begin
         n_fail++;
         $display("FAIL rng_fault got=%b/%h/%b exp=1/0/0", fetch_fault4, pc4, inst_valid4);
      end
      n_run++;
      if (fetch_fault !== 1'b0 || pc !== 32'h40) begin
         n_fail++;
         $display("FAIL rng_big got=%b/%h exp=0/40", fetch_fault, pc);
      end
      boot();
      Branch = 1; Zero = 1; Addr_result = 32'h3C;
      step();
      clr();
      n_run++;
      if (fetch_fault4 !== 1'b0 || pc4 !== 32'h3C) begin
         n_fail++;
         $display("FAIL rng_edge got=%b/%h exp=0/3c", fetch_fault4, pc4);
      end
      boot();
      Branch = 1; Zero = 1; Addr_result = 32'h42;
      step();
      clr();
      n_run++;
      if (fetch_fault !== 1'b1 || pc !== 32'h0) begin
         n_fail++;
         $display("FAIL br_align got=%b/%h exp=1/0", fetch_fault, pc);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++)
         rom[i] = {8'(i) ^ 8'h5A, 8'hC3, 8'(255 - i), 2'b01, 6'(i)};
      clr();
      test_reset();
      test_branch();
      test_jump();
      test_jr_fault();
      test_stall();
      test_reset_pulse();
      test_rom_range();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
